// File: rtl/btn_cmd_decoder_pkg.sv
// btn_cmd_decoder_pkg: shared state type, default timings and command casts for the button front-end.
// Strobe bit order matches con_op_t / clock_op_t: bit5 display_time .. bit0 up.
package btn_cmd_decoder_pkg;
    typedef enum logic [1:0] {IDLE, PRESSED, HELD, REPEAT} btn_state_t;
    localparam int BTN_COUNT            = 6;
    localparam int BTN_DEBOUNCE_DEFAULT = 20000;
    localparam int BTN_LONG_DEFAULT     = 2000000;
    localparam int BTN_REPEAT_DEFAULT   = 500000;
    typedef struct packed {
        logic display_time;
        logic alarm_toggle;
        logic set_alarm;
        logic set_time;
        logic left;
        logic up;
    } con_op_t;
    typedef con_op_t clock_op_t;
    function automatic con_op_t to_con_op(input logic [BTN_COUNT-1:0] strobes);
        return con_op_t'(strobes);
    endfunction
    function automatic logic [BTN_COUNT-1:0] from_con_op(input con_op_t op);
        return BTN_COUNT'(op);
    endfunction
endpackage

// File: rtl/btn_cmd_decoder_channel.sv
// btn_cmd_decoder_channel: one button channel -- 2-FF synchroniser, debounce and press/long/repeat FSM.
// Ports: clk, rst (async, active-high), enable, raw (async button pin),
//        level (debounced, registered), press / long_press (next-cycle strobe candidates, combinational
//        from registered state and enable, registered by the top).
module btn_cmd_decoder_channel
    import btn_cmd_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = BTN_LONG_DEFAULT,
    parameter int REPEAT_CYCLES     = BTN_REPEAT_DEFAULT,
    parameter bit REPEAT_EN         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic raw,
    output logic level,
    output logic press,
    output logic long_press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [DW-1:0] DB_TC   = DW'(DEBOUNCE_CYCLES - 1);
    // hold_cnt reaches LONG_PRESS_CYCLES-1 on the edge that also registers the long strobe
    localparam logic [HW-1:0] LONG_TC = HW'(LONG_PRESS_CYCLES - 2);
    localparam logic [RW-1:0] RPT_TC  = RW'(REPEAT_CYCLES - 1);

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rpt_cnt;
    btn_state_t    state;
    logic          s;
    logic          settle;
    logic          rise;
    logic          fall;

    assign s      = sync[1];
    assign settle = (s != level) && (db_cnt == DB_TC);
    assign rise   = settle && s;
    assign fall   = settle && !s;

    // Strobes are decided on the same edge the level changes so press lines up with the level rise
    assign press      = enable && ((state == IDLE && rise) ||
                                   (state == REPEAT && !fall && rpt_cnt == RPT_TC));
    assign long_press = enable && state == PRESSED && !fall && hold_cnt == LONG_TC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            db_cnt   <= '0;
            level    <= 1'b0;
            state    <= IDLE;
            hold_cnt <= '0;
            rpt_cnt  <= '0;
        end else begin
            sync   <= {sync[0], raw};
            db_cnt <= (s == level || settle) ? '0 : db_cnt + 1'b1;
            if (settle)
                level <= s;
            if (!enable || fall) begin
                state    <= IDLE;
                hold_cnt <= '0;
                rpt_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        state    <= PRESSED;
                        hold_cnt <= '0;
                    end
                    PRESSED: begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == LONG_TC) begin
                            state   <= REPEAT_EN ? REPEAT : HELD;
                            rpt_cnt <= '0;
                        end
                    end
                    REPEAT: rpt_cnt <= (rpt_cnt == RPT_TC) ? '0 : rpt_cnt + 1'b1;
                    HELD: state <= HELD;
                endcase
            end
        end
    end
endmodule

// File: rtl/btn_cmd_decoder.sv
// btn_cmd_decoder: N raw push-buttons to debounced levels and one-cycle press/long-press command strobes.
// Ports: clk, rst (async, active-high), enable (0 masks strobes, holds FSMs idle), btn_raw[N] (async pins),
//        btn_level[N] (debounced), cmd_press[N], cmd_long[N], cmd_conflict (several press candidates
//        when ONE_HOT). All outputs registered.
module btn_cmd_decoder
    import btn_cmd_decoder_pkg::*;
#(
    parameter int                   N_BUTTONS         = BTN_COUNT,
    parameter int                   DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
    parameter int                   LONG_PRESS_CYCLES = BTN_LONG_DEFAULT,
    parameter int                   REPEAT_CYCLES     = BTN_REPEAT_DEFAULT,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK       = N_BUTTONS'(6'b000011),
    parameter bit                   ONE_HOT           = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] cmd_press,
    output logic [N_BUTTONS-1:0] cmd_long,
    output logic                 cmd_conflict
);
    logic [N_BUTTONS-1:0] press_cand;
    logic [N_BUTTONS-1:0] long_cand;
    logic [N_BUTTONS-1:0] press_sel;

    genvar i;
    generate
        for (i = 0; i < N_BUTTONS; i++) begin : g_ch
            btn_cmd_decoder_channel #(
                .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
                .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
                .REPEAT_CYCLES    (REPEAT_CYCLES),
                .REPEAT_EN        (REPEAT_MASK[i])
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .enable    (enable),
                .raw       (btn_raw[i]),
                .level     (btn_level[i]),
                .press     (press_cand[i]),
                .long_press(long_cand[i])
            );
        end
    endgenerate

    // Highest index candidate wins; losers have already advanced their own FSMs
    always_comb begin
        press_sel = '0;
        for (int k = 0; k < N_BUTTONS; k++)
            if (press_cand[k]) begin
                press_sel    = '0;
                press_sel[k] = 1'b1;
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_press    <= '0;
            cmd_long     <= '0;
            cmd_conflict <= 1'b0;
        end else begin
            cmd_press    <= ONE_HOT ? press_sel : press_cand;
            cmd_long     <= long_cand;
            cmd_conflict <= ONE_HOT && ($countones(press_cand) > 1);
        end
    end
endmodule

// File: tb/tb_btn_cmd_decoder.sv
// tb_btn_cmd_decoder: scoreboard bench for btn_cmd_decoder against a time-based behavioural model.
module tb_btn_cmd_decoder;
    localparam int N = 6, DEB = 4, LONG = 20, RPT = 5;
    localparam logic [5:0] MASK = 6'b000011;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [5:0] btn_raw;
    logic [5:0] btn_level;
    logic [5:0] cmd_press;
    logic [5:0] cmd_long;
    logic       cmd_conflict;

    btn_cmd_decoder #(
        .N_BUTTONS        (N),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .REPEAT_CYCLES    (RPT),
        .REPEAT_MASK      (MASK),
        .ONE_HOT          (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .cmd_press   (cmd_press),
        .cmd_long    (cmd_long),
        .cmd_conflict(cmd_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] press;
        logic [5:0] lng;
        logic       conflict;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [5:0] raw_q[$];
    logic [5:0] s_q[$];
    logic [5:0] m_level = '0;
    logic [5:0] s, nl, cp, cl, ep;
    logic       ec;
    bit         all_diff;
    int         pc[N];
    int         age;

    // Model: level flips once the last DEB synchronised samples all disagree with it; strobes follow
    // from the age of the press (cycles since the enabled level rise).
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            raw_q.delete();
            s_q.delete();
            sb.delete();
            m_level = '0;
            for (int i = 0; i < N; i++) pc[i] = -1;
        end else begin
            s = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 6'b0;
            raw_q.push_back(btn_raw);
            if (raw_q.size() > 2) void'(raw_q.pop_front());
            s_q.push_back(s);
            if (s_q.size() > DEB) void'(s_q.pop_front());
            nl = m_level;
            cp = '0;
            cl = '0;
            for (int i = 0; i < N; i++) begin
                if (s_q.size() == DEB) begin
                    all_diff = 1'b1;
                    foreach (s_q[j]) if (s_q[j][i] == m_level[i]) all_diff = 1'b0;
                    if (all_diff) nl[i] = ~m_level[i];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!enable || (m_level[i] && !nl[i])) pc[i] = -1;
                else if (!m_level[i] && nl[i]) begin
                    cp[i] = 1'b1;
                    pc[i] = cyc;
                end else if (pc[i] >= 0) begin
                    age = cyc - pc[i];
                    if (age == LONG - 1) cl[i] = 1'b1;
                    if (MASK[i] && age > LONG - 1 && (age - (LONG - 1)) % RPT == 0) cp[i] = 1'b1;
                end
            end
            ep = cp;
            ec = 1'b0;
            if ($countones(cp) > 1) begin
                ec = 1'b1;
                ep = '0;
                for (int i = N - 1; i >= 0; i--) if (cp[i] && ep == 6'b0) ep[i] = 1'b1;
            end
            if (ep != 6'b0 || cl != 6'b0 || ec) sb.push_back('{cyc, ep, cl, ec});
            m_level = nl;
        end
    end

    // Monitor: compares level every cycle and pops an expectation whenever a strobe is shown or due
    initial forever begin
        @(posedge clk);
        #1;
        checks++;
        if (btn_level !== m_level) begin
            failures++;
            $display("FAIL level cyc=%0d actual=%b expected=%b", cyc, btn_level, m_level);
        end
        if (cmd_press != 6'b0 || cmd_long != 6'b0 || cmd_conflict || (sb.size() > 0 && sb[0].cyc == cyc)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d press=%b long=%b conflict=%b expected none",
                         cyc, cmd_press, cmd_long, cmd_conflict);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.press !== cmd_press || e.lng !== cmd_long || e.conflict !== cmd_conflict) begin
                    failures++;
                    $display("FAIL strobe cyc=%0d press=%b long=%b conflict=%b expected cyc=%0d press=%b long=%b conflict=%b",
                             cyc, cmd_press, cmd_long, cmd_conflict, e.cyc, e.press, e.lng, e.conflict);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        btn_raw = 6'h3F;
        step(4);
        check("reset_press", cmd_press, 6'b0);
        check("reset_long", cmd_long, 6'b0);
        check("reset_conflict", {5'b0, cmd_conflict}, 6'b0);
        check("reset_level", btn_level, 6'b0);
        rst = 1'b0;
        step(5);
        check("held_reset_early", cmd_press, 6'b0);
        step(1);
        check("held_reset_press", cmd_press, 6'b100000);
        check("held_reset_conflict", {5'b0, cmd_conflict}, 6'd1);
        step(30);
        btn_raw = 6'b0;
        step(20);
        btn_raw = 6'b100000;
        step(3);
        btn_raw = 6'b0;
        step(1);
        btn_raw = 6'b100000;
        step(5);
        check("bounce_early", cmd_press, 6'b0);
        step(1);
        check("bounce_press", cmd_press, 6'b100000);
        step(4);
        btn_raw = 6'b0;
        step(20);
        btn_raw = 6'b000001;
        step(6);
        check("rep_press", cmd_press, 6'b000001);
        step(19);
        check("rep_long", cmd_long, 6'b000001);
        step(5);
        check("rep_tick1", cmd_press, 6'b000001);
        step(5);
        check("rep_tick2", cmd_press, 6'b000001);
        step(25);
        btn_raw = 6'b0;
        step(20);
        btn_raw = 6'b010000;
        step(6);
        check("norep_press", cmd_press, 6'b010000);
        step(19);
        check("norep_long", cmd_long, 6'b010000);
        step(5);
        check("norep_quiet", cmd_press, 6'b0);
        step(30);
        btn_raw = 6'b0;
        step(20);
        btn_raw = 6'b000110;
        step(6);
        check("simul_press", cmd_press, 6'b000100);
        check("simul_conflict", {5'b0, cmd_conflict}, 6'd1);
        step(1);
        check("simul_conflict_once", {5'b0, cmd_conflict}, 6'b0);
        step(10);
        btn_raw = 6'b0;
        step(20);
        enable = 1'b0;
        btn_raw = 6'b001000;
        step(15);
        enable = 1'b1;
        step(30);
        btn_raw = 6'b0;
        step(15);
        btn_raw = 6'b001000;
        step(6);
        check("enable_repress", cmd_press, 6'b001000);
        step(5);
        btn_raw = 6'b0;
        step(20);
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 39) == 0) btn_raw[b] = ~btn_raw[b];
            if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 29) == 0) enable = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                step(2);
                rst = 1'b0;
            end
            step(1);
        end
        enable = 1'b1;
        btn_raw = 6'b0;
        step(30);
        check("scoreboard_drain", 6'(sb.size()), 6'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
